writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Producer side of the register file write port (rd, wdata, we). Merges two result sources into the single write port:
  - single-cycle ALU results;
  - variable-latency load responses from the LSU, with byte/half extraction and sign or zero extension.
- Holds a per-register pending-load scoreboard so decode can stall on RAW and WAW hazards against loads still in flight.
- Sits between execute/LSU and the register file, which writes on posedge clk.

Parameters:
- LQ_DEPTH, 2: load-response queue entries; legal values 2–8.
- STALL_ON_FULL, 1: 1 = assert wb_stall when the queue is full; 0 = never assert wb_stall (bench-only mode).

Ports:
- clk  in  1  system clock, posedge
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- ld_issue  in  1  load dispatched this cycle
- ld_issue_rd  in  5  destination register of the dispatched load
- lsu_valid  in  1  load response valid
- lsu_ready  out  1  queue can accept a response; equals (count < LQ_DEPTH)
- lsu_rd  in  5  response destination register
- lsu_rdata  in  32  raw aligned memory word
- lsu_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- lsu_addr_lo  in  2  byte offset within the word
- rs1_q  in  5  decode source register 1 query
- rs2_q  in  5  decode source register 2 query
- busy_rs1  out  1  pending[rs1_q], combinational
- busy_rs2  out  1  pending[rs2_q], combinational
- wb_stall  out  1  queue full; execute must drive alu_valid=0
- rd  out  5  register file write address, registered
- wdata  out  32  register file write data, registered
- we  out  1  register file write enable, registered

Behaviour:
- Reset (asynchronous, active-high):
  - rd=0, wdata=0, we=0.
  - Queue emptied; count=0, so lsu_ready=1 and wb_stall=0.
  - All pending bits cleared.
  - Reset asserted mid-operation drops every queued and in-flight result. Upstream must re-issue.
- Accept: the queue pushes when lsu_valid && lsu_ready.
  - Extraction and extension happen before the push.
  - byte = lsu_rdata[8*addr_lo +: 8]; half = lsu_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - Any other funct3 is treated as LW.
- Arbitration, once per cycle:
  - If wb_stall=1 or alu_valid=0, and the queue is non-empty: pop the head to the output registers.
  - Otherwise, if alu_valid=1: the ALU result goes to the output registers.
  - A push and a pop in the same cycle are legal at any occupancy, including full.
- Output registers:
  - we <= selected source valid AND (selected rd != 0).
  - rd and wdata load whenever a source is selected, even when rd=0.
  - When no source is selected, we <= 0 and rd/wdata hold their values.
- Latency:
  - ALU: presented at cycle N, we=1 at N+1, register written at the N+2 edge.
  - Load into an empty queue with no ALU traffic: pushed at N, head at N+1, we=1 at N+2.
- Scoreboard (pending[31:1], pending[0] tied to 0):
  - Set at the edge where ld_issue=1 and ld_issue_rd!=0.
  - Cleared at the edge where the output registers present that rd with we=1 from the queue path. The register file commits one edge later, so the bit stays high through the write-commit edge. Implement this with a one-cycle delayed clear.
  - Simultaneous set and clear of the same rd: set wins.
- Protocol assertions:
  - ld_issue to a register whose pending bit is set.
  - alu_valid=1 while wb_stall=1.
  - alu_rd with a pending bit set, except rd=0.
  - lsu_valid while lsu_ready=0 is ignored, not pushed.
- wb_stall = STALL_ON_FULL && (count == LQ_DEPTH), combinational from the registered count.

Decomposition:
- Shared package (cpu_pkg):
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - wb_entry_t struct {rd[4:0], data[31:0]};
  - REG_ZERO constant.
- Sub-module wb_lq_fifo:
  - parameterised LQ_DEPTH circular buffer of wb_entry_t;
  - count, full and empty flags;
  - asynchronous reset;
  - simultaneous push/pop at full.
- The extension logic stays as a function in the package.

Test Plan:
- ALU write: alu_valid=1, alu_rd=5, alu_wdata=0xDEADBEEF at cycle 3 → we=1, rd=5, wdata=0xDEADBEEF at cycle 4; we=0 at cycle 5.
- Zero register: alu_rd=0, wdata=0x1234 → we stays 0. ld_issue_rd=0 → busy never set for x0.
- Extension: lsu_rdata=0x80F0_7F81.
  - LB, addr_lo=0 → 0xFFFFFF81.
  - LBU, addr_lo=3 → 0x00000080.
  - LH, addr_lo=2 → 0xFFFF80F0.
  - LHU, addr_lo=0 → 0x00007F81.
  - LW → 0x80F07F81.
- Scoreboard/RAW:
  - ld_issue rd=7 → busy_rs1=1 for rs1_q=7 the next cycle.
  - After the response reaches the output with we=1, busy drops exactly one cycle after we.
- Contention:
  - ALU valid every cycle while LQ_DEPTH=2 responses arrive → queue fills, wb_stall=1, lsu_ready=0.
  - Bench then drops alu_valid → queue drains in order, wb_stall falls.
- Reset mid-drain: assert reset with 2 entries queued → we=0 and lsu_ready=1 immediately, all busy bits 0, no stale write after reset releases.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared writeback definitions: load funct3 encodings, queue entry type and
// the load byte/half extraction and extension helper.
package cpu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Queue occupancy width; covers 0..8 entries.
  localparam int unsigned LQ_CNT_W = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Unknown funct3 values fall through to a full-word load.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LBU:  res = {24'd0, b};
      F3_LHU:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_lq_fifo.sv
// Circular load-response queue; a pop frees a slot for a push in the same
// cycle, so push+pop at full is accepted.
module wb_lq_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  wb_entry_t           push_data,
  input  logic                pop,
  output wb_entry_t           head,
  output logic [LQ_CNT_W-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t           mem_q [DEPTH];
  wb_entry_t           mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LQ_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == LQ_CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + LQ_CNT_W'(do_push) - LQ_CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: merges ALU results with queued load
// responses and tracks loads in flight for decode hazard checks.
module writeback_unit
  import cpu_pkg::*;
#(
  parameter int unsigned LQ_DEPTH      = 2,
  parameter bit          STALL_ON_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_rdata,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_addr_lo,
  input  logic [4:0]  rs1_q,
  input  logic [4:0]  rs2_q,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        wb_stall,
  output logic [4:0]  rd,
  output logic [31:0] wdata,
  output logic        we
);

  wb_entry_t           lq_head, lq_in;
  logic [LQ_CNT_W-1:0] lq_count;
  logic                lq_full, lq_empty, lq_push, lq_pop;

  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        from_lq_q, from_lq_d;
  logic [31:0] pending_q, pending_d;

  assign lsu_ready = (lq_count < LQ_CNT_W'(LQ_DEPTH));
  assign wb_stall  = STALL_ON_FULL && lq_full;
  assign busy_rs1  = pending_q[rs1_q];
  assign busy_rs2  = pending_q[rs2_q];
  assign rd        = rd_q;
  assign wdata     = wdata_q;
  assign we        = we_q;

  assign lq_push = lsu_valid && lsu_ready;
  assign lq_in   = '{rd: lsu_rd, data: load_extend(lsu_rdata, lsu_funct3, lsu_addr_lo)};
  assign lq_pop  = (wb_stall || !alu_valid) && !lq_empty;

  wb_lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (lq_push),
    .push_data (lq_in),
    .pop       (lq_pop),
    .head      (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // Queue head has priority when the ALU is idle or being held off.
  always_comb begin
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    from_lq_d = 1'b0;
    if (lq_pop) begin
      rd_d      = lq_head.rd;
      wdata_d   = lq_head.data;
      we_d      = (lq_head.rd != REG_ZERO);
      from_lq_d = 1'b1;
    end else if (alu_valid) begin
      rd_d    = alu_rd;
      wdata_d = alu_wdata;
      we_d    = (alu_rd != REG_ZERO);
    end
  end

  // Clear lags the load write by one edge so the bit covers the commit edge.
  always_comb begin
    pending_d = pending_q;
    if (we_q && from_lq_q) pending_d[rd_q] = 1'b0;
    if (ld_issue && (ld_issue_rd != REG_ZERO)) pending_d[ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      from_lq_q <= 1'b0;
      pending_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      from_lq_q <= from_lq_d;
      pending_q <= pending_d;
    end
  end

  a_ld_issue_pending: assert property (@(posedge clk) disable iff (reset)
    !(ld_issue && pending_q[ld_issue_rd]));
  a_alu_while_stall: assert property (@(posedge clk) disable iff (reset)
    !(alu_valid && wb_stall));
  a_alu_rd_pending: assert property (@(posedge clk) disable iff (reset)
    !(alu_valid && pending_q[alu_rd]));

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed checks of writeback_unit against a queue-level model.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_issue, lsu_valid;
  logic [4:0]  alu_rd, ld_issue_rd, lsu_rd, rs1_q, rs2_q;
  logic [31:0] alu_wdata, lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        lsu_ready, busy_rs1, busy_rs2, wb_stall, we;
  logic [4:0]  rd;
  logic [31:0] wdata;

  writeback_unit #(.LQ_DEPTH(DEPTH), .STALL_ON_FULL(1'b1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rdata(lsu_rdata), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .wb_stall(wb_stall), .rd(rd), .wdata(wdata), .we(we)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: queued results, outstanding loads, pending bits, outputs.
  logic [36:0] lq[$];
  logic [4:0]  issued[$];
  bit   [31:0] m_pend;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  bit          m_we, m_from_lq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [31:0] bs, hs;
    bs = w >> (8 * int'(lo));
    hs = lo[1] ? (w >> 16) : w;
    case (f3)
      3'd0:    return bs[7] ? (bs | 32'hFFFF_FF00) : (bs & 32'h0000_00FF);
      3'd1:    return hs[15] ? (hs | 32'hFFFF_0000) : (hs & 32'h0000_FFFF);
      3'd4:    return bs & 32'h0000_00FF;
      3'd5:    return hs & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_wdata = 0;
    ld_issue = 0; ld_issue_rd = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_addr_lo = 0;
  endtask

  task automatic model_reset();
    lq.delete(); issued.delete();
    m_pend = '0; m_rd = '0; m_wdata = '0; m_we = 0; m_from_lq = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic tick();
    bit          stall, ready, clr;
    logic [4:0]  clr_rd;
    logic [36:0] e;
    #1;
    stall = (lq.size() == DEPTH);
    ready = (lq.size() < DEPTH);
    chk("lsu_ready", 32'(lsu_ready), 32'(ready));
    chk("wb_stall", 32'(wb_stall), 32'(stall));
    chk("busy_rs1", 32'(busy_rs1), 32'(m_pend[rs1_q]));
    chk("busy_rs2", 32'(busy_rs2), 32'(m_pend[rs2_q]));
    clr = m_we && m_from_lq;
    clr_rd = m_rd;
    if ((stall || !alu_valid) && lq.size() > 0) begin
      e = lq.pop_front();
      m_rd = e[36:32]; m_wdata = e[31:0]; m_we = (m_rd != 0); m_from_lq = 1;
    end else if (alu_valid) begin
      m_rd = alu_rd; m_wdata = alu_wdata; m_we = (alu_rd != 0); m_from_lq = 0;
    end else begin
      m_we = 0; m_from_lq = 0;
    end
    if (lsu_valid && ready) lq.push_back({lsu_rd, ref_ext(lsu_rdata, lsu_funct3, lsu_addr_lo)});
    if (clr) m_pend[clr_rd] = 0;
    if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1;
    @(posedge clk);
    @(negedge clk);
    chk("we", 32'(we), 32'(m_we));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("wdata", wdata, m_wdata);
  endtask

  logic [31:0] ext_word;
  logic [2:0]  ext_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ext_lo  [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] ext_exp [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                               32'h0000_7F81, 32'h80F0_7F81};

  initial begin
    logic [4:0] r;
    idle_inputs();
    rs1_q = 0; rs2_q = 0;
    model_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_stall", 32'(wb_stall), 32'd0);
    reset = 0;
    tick(); tick();

    // ALU write lands one cycle later, then we drops.
    alu_valid = 1; alu_rd = 5; alu_wdata = 32'hDEAD_BEEF;
    tick();
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_rd", 32'(rd), 32'd5);
    chk("alu_wdata", wdata, 32'hDEAD_BEEF);
    idle_inputs();
    tick();
    chk("alu_we_drop", 32'(we), 32'd0);

    // x0 is never written and never marked busy.
    alu_valid = 1; alu_rd = 0; alu_wdata = 32'h1234;
    ld_issue = 1; ld_issue_rd = 0;
    tick();
    chk("x0_we", 32'(we), 32'd0);
    idle_inputs();
    rs1_q = 0;
    #1 chk("x0_busy", 32'(busy_rs1), 32'd0);
    tick();

    // Extension cases plus busy timing around the load write.
    ext_word = 32'h80F0_7F81;
    for (int i = 0; i < 5; i++) begin
      r = (i == 0) ? 5'd7 : 5'(10 + i);
      ld_issue = 1; ld_issue_rd = r;
      tick();
      idle_inputs();
      rs1_q = r;
      #1 chk("raw_busy", 32'(busy_rs1), 32'd1);
      lsu_valid = 1; lsu_rd = r; lsu_rdata = ext_word;
      lsu_funct3 = ext_f3[i]; lsu_addr_lo = ext_lo[i];
      tick();
      idle_inputs();
      tick();
      chk("ext_we", 32'(we), 32'd1);
      chk("ext_data", wdata, ext_exp[i]);
      #1 chk("busy_during_we", 32'(busy_rs1), 32'd1);
      tick();
      #1 chk("busy_drop", 32'(busy_rs1), 32'd0);
    end

    // Contention: ALU every cycle while two responses fill the queue.
    rs1_q = 20; rs2_q = 21;
    alu_valid = 1; alu_rd = 3; alu_wdata = 32'h1111_0000;
    ld_issue = 1; ld_issue_rd = 20;
    tick();
    alu_wdata = 32'h1111_0001; ld_issue_rd = 21;
    lsu_valid = 1; lsu_rd = 20; lsu_rdata = 32'hAAAA_0020; lsu_funct3 = 3'b010;
    tick();
    ld_issue = 0; alu_wdata = 32'h1111_0002;
    lsu_rd = 21; lsu_rdata = 32'hAAAA_0021;
    tick();
    idle_inputs();
    #1;
    chk("full_stall", 32'(wb_stall), 32'd1);
    chk("full_ready", 32'(lsu_ready), 32'd0);
    tick();
    chk("drain0_rd", 32'(rd), 32'd20);
    chk("drain0_data", wdata, 32'hAAAA_0020);
    #1 chk("stall_fall", 32'(wb_stall), 32'd0);
    tick();
    chk("drain1_rd", 32'(rd), 32'd21);
    chk("drain1_data", wdata, 32'hAAAA_0021);
    tick(); tick();

    // Reset with two queued loads drops everything.
    rs1_q = 22; rs2_q = 23;
    alu_valid = 1; alu_rd = 4; alu_wdata = 32'h2222_0000;
    ld_issue = 1; ld_issue_rd = 22;
    tick();
    ld_issue_rd = 23; lsu_valid = 1; lsu_rd = 22; lsu_rdata = 32'hBBBB_0022;
    tick();
    ld_issue = 0; lsu_rd = 23; lsu_rdata = 32'hBBBB_0023;
    tick();
    idle_inputs();
    reset = 1;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_ready", 32'(lsu_ready), 32'd1);
    chk("mid_rst_busy1", 32'(busy_rs1), 32'd0);
    chk("mid_rst_busy2", 32'(busy_rs2), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    repeat (4) tick();

    // Randomized traffic that respects the upstream protocol.
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rs1_q = 5'($urandom_range(0, 31));
      rs2_q = 5'($urandom_range(0, 31));
      if (lq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        alu_valid = 1;
        alu_rd = 5'($urandom_range(0, 31));
        if (m_pend[alu_rd]) alu_rd = 0;
        alu_wdata = $urandom;
      end
      ld_issue_rd = 5'($urandom_range(0, 31));
      ld_issue = ($urandom_range(0, 3) == 0) && !m_pend[ld_issue_rd];
      if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
        lsu_valid = 1; lsu_rd = issued[0];
        lsu_rdata = $urandom;
        lsu_funct3 = 3'($urandom_range(0, 7));
        lsu_addr_lo = 2'($urandom_range(0, 3));
        if (lq.size() < DEPTH) void'(issued.pop_front());
      end
      if (ld_issue) issued.push_back(ld_issue_rd);
      tick();
    end

    idle_inputs();
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
